// File: rtl/ring_code_monitor.sv
// ring_code_monitor: checks the one-hot ring code, encodes it to a binary index, counts revolutions.
// Define RING_MON_ERR_COUNT_EN to add the saturating err_count output.
module ring_code_monitor #(
  parameter int WIDTH    = 4,
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     clear_err,
  output logic [$clog2(WIDTH)-1:0] index,
  output logic                     index_valid,
  output logic                     locked,
  output logic                     err,
  output logic [CNT_W-1:0]         rev_count,
  output logic                     rev_tick
`ifdef RING_MON_ERR_COUNT_EN
  ,
  output logic [7:0]               err_count
`endif
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int LCW   = $clog2(LOCK_CNT + 1);

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_LOCKED = 2'd1;
  localparam logic [1:0] S_FAULT  = 2'd2;

  logic [WIDTH-1:0] r_dq;
  logic [WIDTH-1:0] r_prevQ;
  logic [1:0]       r_state;
  logic [LCW-1:0]   r_lockCnt;

  logic [WIDTH-1:0] w_rot;
  logic             w_legal;
  logic             w_step;
  logic             w_hold;
  logic             w_wrap;
  logic             w_toFault;
  logic [IDX_W-1:0] w_enc;
  logic [1:0]       w_nextState;
  logic [LCW-1:0]   w_nextCnt;

  assign w_rot   = {r_prevQ[WIDTH-2:0], r_prevQ[WIDTH-1]};
  assign w_legal = (r_dq != '0) && ((r_dq & (r_dq - WIDTH'(1))) == '0);
  // Only a one-hot sample can be a rotation step, so zero followed by zero never counts toward lock.
  assign w_step  = w_legal && (r_dq == w_rot);
  assign w_hold  = w_legal && (r_dq == r_prevQ);
  assign w_wrap  = w_step && r_dq[0];
  assign w_toFault = (r_state == S_LOCKED) && (w_nextState == S_FAULT);

  always_comb begin
    w_enc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_dq[i]) w_enc = w_enc | IDX_W'(i);
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_lockCnt;
    case (r_state)
      S_SEARCH: begin
        if (w_step)       w_nextCnt = r_lockCnt + LCW'(1);
        else if (!w_hold) w_nextCnt = '0;
        if (w_nextCnt == LCW'(LOCK_CNT)) begin
          w_nextState = S_LOCKED;
          w_nextCnt   = '0;
        end
      end
      S_LOCKED: begin
        w_nextCnt = '0;
        if (!(w_step || w_hold)) w_nextState = S_FAULT;
      end
      S_FAULT: begin
        if (clear_err) begin
          w_nextState = S_SEARCH;
          w_nextCnt   = '0;
        end
      end
      default: begin
        w_nextState = S_SEARCH;
        w_nextCnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dq        <= '0;
      r_prevQ     <= '0;
      r_state     <= S_SEARCH;
      r_lockCnt   <= '0;
      index       <= '0;
      index_valid <= 1'b0;
      locked      <= 1'b0;
      err         <= 1'b0;
      rev_count   <= '0;
      rev_tick    <= 1'b0;
    end else begin
      r_dq        <= data_in;
      r_prevQ     <= r_dq;
      r_state     <= w_nextState;
      r_lockCnt   <= w_nextCnt;
      if (w_legal) index <= w_enc;
      index_valid <= w_legal && (r_state != S_FAULT);
      locked      <= (w_nextState == S_LOCKED);
      rev_tick    <= (r_state == S_LOCKED) && w_wrap;
      if ((r_state == S_LOCKED) && w_wrap) rev_count <= rev_count + CNT_W'(1);
      if (w_toFault) err <= 1'b1;
      else if ((r_state == S_FAULT) && clear_err) err <= 1'b0;
    end
  end

`ifdef RING_MON_ERR_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (w_toFault && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ring_code_monitor.sv
// Scoreboarded bench for ring_code_monitor: directed test-plan phases followed by random ring traffic,
// checked against a sample-history reference model.
module tb_ring_code_monitor;

   localparam int W     = 4;
   localparam int CNTW  = 8;
   localparam int LOCKN = 2;

   localparam int MODE_SEARCH = 0;
   localparam int MODE_LOCKED = 1;
   localparam int MODE_FAULT  = 2;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic [W-1:0]         dataIn = '0;
   logic                 clearErr = 1'b0;
   logic [$clog2(W)-1:0] index;
   logic                 indexValid;
   logic                 locked;
   logic                 err;
   logic [CNTW-1:0]      revCount;
   logic                 revTick;
`ifdef RING_MON_ERR_COUNT_EN
   logic [7:0]           errCount;
`endif

   typedef struct {
      int idx;
      int vld;
      int lck;
      int er;
      int rc;
      int tk;
      int ec;
   } exp_t;

   exp_t expQ[$];

   int checks = 0;
   int failures = 0;

   int h1 = 0, h2 = 0;
   int mMode = MODE_SEARCH, mCnt = 0, mIdx = 0, mRev = 0, mErr = 0, mErrCnt = 0;
   logic [W-1:0] cur;

   ring_code_monitor #(.WIDTH(W), .CNT_W(CNTW), .LOCK_CNT(LOCKN)) dut (
      .clk(clk),
      .reset(reset),
      .data_in(dataIn),
      .clear_err(clearErr),
      .index(index),
      .index_valid(indexValid),
      .locked(locked),
      .err(err),
      .rev_count(revCount),
      .rev_tick(revTick)
`ifdef RING_MON_ERR_COUNT_EN
      ,
      .err_count(errCount)
`endif
   );

   // Free-running clock, 10 time-unit period
   always #5 clk = ~clk;

   function automatic int rotl(input int p);
      return ((p << 1) | (p >> (W - 1))) & ((1 << W) - 1);
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one call per clock edge, using the two most recent samples of data_in
   task automatic modelEdge(input logic [W-1:0] d, input logic clr);
      exp_t e;
      bit legal, step, hold, wrap, tick;
      legal = ($countones(h1) == 1);
      step  = legal && (h1 == rotl(h2));
      hold  = legal && (h1 == h2);
      wrap  = step && ((h1 & 1) != 0);
      tick  = 0;
      e.vld = (legal && (mMode != MODE_FAULT)) ? 1 : 0;
      if (legal) mIdx = $clog2(h1);
      case (mMode)
         MODE_SEARCH: begin
            if (step)       mCnt++;
            else if (!hold) mCnt = 0;
            if (mCnt == LOCKN) begin
               mMode = MODE_LOCKED;
               mCnt  = 0;
            end
         end
         MODE_LOCKED: begin
            if (wrap) begin
               mRev = (mRev + 1) % (1 << CNTW);
               tick = 1;
            end
            if (!(step || hold)) begin
               mMode = MODE_FAULT;
               mErr  = 1;
               if (mErrCnt < 255) mErrCnt++;
            end
         end
         default: begin
            if (clr) begin
               mMode = MODE_SEARCH;
               mCnt  = 0;
               mErr  = 0;
            end
         end
      endcase
      e.idx = mIdx;
      e.lck = (mMode == MODE_LOCKED) ? 1 : 0;
      e.er  = mErr;
      e.rc  = mRev;
      e.tk  = tick ? 1 : 0;
      e.ec  = mErrCnt;
      expQ.push_back(e);
      h2 = h1;
      h1 = int'(d);
   endtask

   task automatic modelReset();
      h1 = 0; h2 = 0;
      mMode = MODE_SEARCH; mCnt = 0; mIdx = 0; mRev = 0; mErr = 0; mErrCnt = 0;
   endtask

   // Drive one sample on the falling edge and queue the response expected after the next rising edge
   task automatic applyStimulus(input logic [W-1:0] d, input logic clr);
      @(negedge clk);
      dataIn   = d;
      clearErr = clr;
      modelEdge(d, clr);
   endtask

   // Assert reset between edges, check outputs clear without a clock edge, then release
   task automatic resetAndCheck(input string tag);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      checkOutput({tag, "_index"}, int'(index), 0);
      checkOutput({tag, "_index_valid"}, int'(indexValid), 0);
      checkOutput({tag, "_locked"}, int'(locked), 0);
      checkOutput({tag, "_err"}, int'(err), 0);
      checkOutput({tag, "_rev_count"}, int'(revCount), 0);
      checkOutput({tag, "_rev_tick"}, int'(revTick), 0);
`ifdef RING_MON_ERR_COUNT_EN
      checkOutput({tag, "_err_count"}, int'(errCount), 0);
`endif
      modelReset();
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b0;
   endtask

   task automatic runRevs(input int n);
      for (int r = 0; r < n; r++) begin
         for (int b = 0; b < W; b++) begin
            cur = W'(1 << b);
            applyStimulus(cur, 1'b0);
         end
      end
   endtask

   // Monitor: compares every DUT output against the queued expectation one step after each rising edge
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput("index", int'(index), e.idx);
         checkOutput("index_valid", int'(indexValid), e.vld);
         checkOutput("locked", int'(locked), e.lck);
         checkOutput("err", int'(err), e.er);
         checkOutput("rev_count", int'(revCount), e.rc);
         checkOutput("rev_tick", int'(revTick), e.tk);
`ifdef RING_MON_ERR_COUNT_EN
         checkOutput("err_count", int'(errCount), e.ec);
`endif
      end
   end

   initial begin
      int r;
      logic clr;
      resetAndCheck("reset_initial");

      // Normal lock and revolutions, then hold tolerance
      runRevs(4);
      applyStimulus(4'b0001, 1'b0);
      applyStimulus(4'b0010, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(4'b0100, 1'b0);
      applyStimulus(4'b1000, 1'b0);
      runRevs(1);

      // Illegal code fault, then clear and re-lock
      applyStimulus(4'b0110, 1'b0);
      applyStimulus(4'b0001, 1'b0);
      applyStimulus(4'b0010, 1'b0);
      applyStimulus(4'b0100, 1'b1);
      runRevs(2);

      // Skip fault, then clear on the same edge as another illegal sample
      applyStimulus(4'b0001, 1'b0);
      applyStimulus(4'b0100, 1'b0);
      applyStimulus(4'b0110, 1'b0);
      applyStimulus(4'b0110, 1'b0);
      applyStimulus(4'b0000, 1'b1);
      runRevs(2);

      // Lock with five revolutions, then asynchronous reset mid-run
      resetAndCheck("reset_fresh");
      runRevs(6);
      resetAndCheck("reset_midrun");

      // Random traffic: mostly rotation, with holds, garbage, skips, reversals and clears
      cur = 4'b0001;
      for (int n = 0; n < 3000; n++) begin
         r   = int'($urandom_range(0, 99));
         clr = ($urandom_range(0, 15) == 0);
         if (r < 70)      cur = W'(rotl(int'(cur)));
         else if (r < 82) cur = cur;
         else if (r < 90) cur = W'($urandom_range(0, (1 << W) - 1));
         else if (r < 95) cur = W'(rotl(rotl(int'(cur))));
         else             cur = W'(rotl(rotl(rotl(int'(cur)))));
         applyStimulus(cur, clr);
         if ($countones(cur) != 1) cur = 4'b0001;
      end

      @(posedge clk);
      #3;
      checkOutput("queue_drained", expQ.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
